// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, opcode constants and the
// memory-port arbiter state/owner encodings.
package cpu_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_LOAD     = 3'd0;
  localparam logic [2:0] OP_STORE    = 3'd1;
  localparam logic [2:0] OP_BRANCH   = 3'd2;
  localparam logic [2:0] OP_ADD      = 3'd3;
  localparam logic [2:0] OP_SUBTRACT = 3'd4;
  localparam logic [2:0] OP_AND      = 3'd5;
  localparam logic [2:0] OP_OR       = 3'd6;
  localparam logic [2:0] OP_NOOP     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_streak_cnt.sv
// Saturating count of consecutive data grants taken while fetch was waiting;
// at_max tells the arbiter to hand the next slot to fetch.
module arb_streak_cnt #(
  parameter int MAX_STREAK = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [2:0] MAX_C = 3'(MAX_STREAK);

  logic [2:0] cnt_q, cnt_d;

  // next count: clear wins over increment, increment saturates
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access
// at a time; data has priority, bounded by a streak counter so fetch is served.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adrs,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adrs,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              is_rd_q, is_rd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_adrs_q, mem_adrs_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              streak_max_s, idle_s, if_win_s;

  // grants are gated by resetn so nothing is accepted while reset is held
  assign idle_s   = (state_q == ST_IDLE) && resetn;
  assign if_win_s = if_req && (!d_req || streak_max_s);
  assign if_gnt   = idle_s && if_win_s;
  assign d_gnt    = idle_s && d_req && !if_win_s;

  arb_streak_cnt #(.MAX_STREAK(MAX_STREAK)) u_streak (
    .clk    (clk),
    .resetn (resetn),
    .inc    (d_gnt && if_req),
    .clr    (if_gnt || (d_gnt && !if_req)),
    .at_max (streak_max_s)
  );

  // next-state, command and read-return logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_rd_d     = is_rd_q;
    cnt_d       = cnt_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_adrs_d  = mem_adrs_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_gnt) begin
          state_d    = ST_ISSUE;
          owner_d    = OWN_IF;
          is_rd_d    = 1'b1;
          mem_re_d   = 1'b1;
          mem_adrs_d = if_adrs;
        end else if (d_gnt) begin
          state_d    = ST_ISSUE;
          owner_d    = OWN_D;
          is_rd_d    = !d_we;
          mem_re_d   = !d_we;
          mem_we_d   = d_we;
          mem_adrs_d = d_adrs;
          if (d_we) begin
            mem_wdata_d = d_wdata;
          end else begin
            mem_wdata_d = mem_wdata_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (is_rd_q) begin
          state_d = ST_WAIT;
          cnt_d   = RD_LAT_C;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // count of 1 marks the cycle in which mem_rdata is valid
        if (cnt_q == 3'd1) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_D) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      is_rd_q     <= 1'b0;
      cnt_q       <= 3'd0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adrs_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_rd_q     <= is_rd_d;
      cnt_q       <= cnt_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_adrs_q  <= mem_adrs_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_adrs  = mem_adrs_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-schedule reference model
// predicts grants, strobes, read returns and busy cycle by cycle.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int MAX_STREAK = 3;
  localparam int NCYC       = 3000;

  logic              clk, resetn;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_adrs;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_adrs;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_re, mem_we, busy;
  logic [ADDR_W-1:0] mem_adrs;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_adrs(if_adrs), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_adrs(d_adrs), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_adrs(mem_adrs),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // memory environment (answers the DUT's strobes)
  logic [DATA_W-1:0] env_mem [16];
  int                rd_pend_cyc = -1;
  logic [DATA_W-1:0] rd_pend_data;

  // reference model: transaction schedule
  logic [DATA_W-1:0] ref_mem [16];
  int                free_at = 0;
  int                streak_m = 0;
  int                stb_cyc = -1;
  logic              stb_we;
  logic [ADDR_W-1:0] last_adrs;
  logic [DATA_W-1:0] stb_wdata;
  int                rv_cyc = -1;
  logic              rv_data_owner;
  logic [DATA_W-1:0] rv_data;
  logic [DATA_W-1:0] exp_if_rdata, exp_d_rdata;

  // requesters
  logic if_pend = 1'b0, d_pend = 1'b0;
  int   p_if, p_d, rst_pulses = 0, grants_if = 0, grants_d = 0;

  task automatic drive_inputs();
    if (cyc < 3) resetn = 1'b0;
    else if (cyc > 300 && rst_pulses < 4 && rv_cyc >= 0 &&
             cyc >= rv_cyc - RD_LAT && cyc < rv_cyc && $urandom_range(3) == 0) begin
      resetn = 1'b0;
      rst_pulses++;
    end else resetn = 1'b1;

    if (cyc < 600)       begin p_if = 50;  p_d = 50;  end
    else if (cyc < 1200) begin p_if = 100; p_d = 100; end
    else if (cyc < 1800) begin p_if = 100; p_d = 30;  end
    else                 begin p_if = 30;  p_d = 90;  end

    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1'b1;
      if_adrs = ADDR_W'($urandom());
    end
    if (!d_pend && $urandom_range(99) < p_d) begin
      d_pend  = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_adrs  = ADDR_W'($urandom());
      d_wdata = $urandom();
    end
    if_req = if_pend;
    d_req  = d_pend;
    mem_rdata = (rd_pend_cyc == cyc) ? rd_pend_data : $urandom();
  endtask

  task automatic check_and_model();
    bit idle, gi, gd, stb_now, rv_now;
    if (!resetn) begin
      check_eq("rst_if_gnt", if_gnt, 1'b0);
      check_eq("rst_d_gnt", d_gnt, 1'b0);
      check_eq("rst_mem_re", mem_re, 1'b0);
      check_eq("rst_mem_we", mem_we, 1'b0);
      check_eq("rst_mem_adrs", mem_adrs, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_if_rvalid", if_rvalid, 1'b0);
      check_eq("rst_d_rvalid", d_rvalid, 1'b0);
      check_eq("rst_if_rdata", if_rdata, 0);
      check_eq("rst_d_rdata", d_rdata, 0);
      check_eq("rst_busy", busy, 1'b0);
      free_at = cyc; streak_m = 0; stb_cyc = -1; rv_cyc = -1;
      last_adrs = '0; exp_if_rdata = '0; exp_d_rdata = '0;
      return;
    end

    stb_now = (stb_cyc == cyc);
    check_eq("mem_re", mem_re, stb_now && !stb_we);
    check_eq("mem_we", mem_we, stb_now && stb_we);
    check_eq("mem_adrs", mem_adrs, last_adrs);
    if (stb_now && stb_we) check_eq("mem_wdata", mem_wdata, stb_wdata);

    rv_now = (rv_cyc == cyc);
    if (rv_now) begin
      if (rv_data_owner) exp_d_rdata = rv_data;
      else               exp_if_rdata = rv_data;
      rv_cyc = -1;
    end
    check_eq("if_rvalid", if_rvalid, rv_now && !rv_data_owner);
    check_eq("d_rvalid", d_rvalid, rv_now && rv_data_owner);
    check_eq("if_rdata", if_rdata, exp_if_rdata);
    check_eq("d_rdata", d_rdata, exp_d_rdata);
    check_eq("busy", busy, cyc < free_at);

    idle = (cyc >= free_at);
    gi = idle && if_req && (!d_req || streak_m == MAX_STREAK);
    gd = idle && d_req && !gi;
    check_eq("if_gnt", if_gnt, gi);
    check_eq("d_gnt", d_gnt, gd);

    if (gi || gd) begin
      stb_cyc = cyc + 1;
      stb_we  = gd && d_we;
      if (gi) begin
        last_adrs = if_adrs;
        rv_data_owner = 1'b0;
        streak_m = 0;
        grants_if++;
      end else begin
        last_adrs = d_adrs;
        rv_data_owner = 1'b1;
        streak_m = if_req ? ((streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK) : 0;
        grants_d++;
      end
      if (stb_we) begin
        stb_wdata = d_wdata;
        ref_mem[d_adrs[3:0]] = d_wdata;
        free_at = cyc + 2;
      end else begin
        rv_data = ref_mem[last_adrs[3:0]];
        rv_cyc  = cyc + 2 + RD_LAT;
        free_at = rv_cyc;
      end
    end
  endtask

  task automatic env_observe();
    if (if_gnt) if_pend = 1'b0;
    if (d_gnt)  d_pend  = 1'b0;
    if (!resetn) rd_pend_cyc = -1;
    else begin
      if (mem_we) env_mem[mem_adrs[3:0]] = mem_wdata;
      if (mem_re) begin
        rd_pend_cyc  = cyc + RD_LAT;
        rd_pend_data = env_mem[mem_adrs[3:0]];
      end
    end
  endtask

  initial begin
    resetn = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_adrs = '0; d_adrs = '0; d_wdata = '0; mem_rdata = '0;
    last_adrs = '0; exp_if_rdata = '0; exp_d_rdata = '0;
    stb_we = 1'b0; stb_wdata = '0; rv_data = '0; rv_data_owner = 1'b0;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = $urandom();
      ref_mem[i] = env_mem[i];
    end
    @(posedge clk); #1;
    for (int n = 0; n < NCYC; n++) begin
      cyc = n;
      drive_inputs();
      @(negedge clk);
      check_and_model();
      env_observe();
      @(posedge clk); #1;
    end
    check_eq("reset_pulse_seen", rst_pulses > 0, 1'b1);
    check_eq("fetch_served", grants_if > 100, 1'b1);
    check_eq("data_served", grants_d > 100, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store (data) requester. Accepts one access at a time, drives the registered memory strobes and address, waits out the memory read latency, and returns read data to the requester that issued it. Data accesses have priority, and a streak counter guarantees that fetch is not starved. The block sits between the pipeline stages of `cpu` and the instruction/data memory.

## Interface
- `ADDR_W`, 11, memory address width.
- `DATA_W`, 32, memory data width.
- `RD_LAT`, 2, cycles from the `mem_re` cycle to valid `mem_rdata`; legal range 1..7.
- `MAX_STREAK`, 3, maximum consecutive data grants while fetch waits; legal range 1..7.

Ports:
- `clk  in  1`: single clock; all state on rising edge.
- `resetn  in  1`: reset, asynchronous and active-low.
- `if_req  in  1`: fetch read request; held, with `if_adrs`, until `if_gnt`.
- `if_adrs  in  ADDR_W`: fetch address.
- `if_gnt  out  1`: fetch accepted this cycle (combinational).
- `if_rvalid  out  1`: one-cycle pulse; `if_rdata` valid.
- `if_rdata  out  DATA_W`: fetched word (registered).
- `d_req  in  1`: data request; held, with `d_we`/`d_adrs`/`d_wdata`, until `d_gnt`.
- `d_we  in  1`: 1 = store, 0 = load.
- `d_adrs  in  ADDR_W`: data address.
- `d_wdata  in  DATA_W`: store data.
- `d_gnt  out  1`: data access accepted this cycle (combinational).
- `d_rvalid  out  1`: one-cycle pulse for loads only.
- `d_rdata  out  DATA_W`: loaded word (registered).
- `mem_re  out  1`: memory read strobe (registered).
- `mem_we  out  1`: memory write strobe (registered).
- `mem_adrs  out  ADDR_W`: memory address (registered).
- `mem_wdata  out  DATA_W`: memory write data (registered).
- `mem_rdata  in  DATA_W`: memory read data.
- `busy  out  1`: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - The winner is fetch if `if_req && (!d_req || streak == MAX_STREAK)`; otherwise data, if `d_req`.
  - The winner's `gnt` is high for that cycle. The command is registered into the `mem_*` outputs and the state moves to ISSUE.
  - The owner (fetch/data) and the access type are latched.
- **ISSUE:**
  - Exactly one cycle with `mem_re` or `mem_we` high.
  - A write goes to IDLE.
  - A read goes to WAIT with the countdown set to `RD_LAT`.
- **WAIT:**
  - The countdown decrements each cycle.
  - In the cycle where `mem_rdata` is valid (countdown reaches 1), the data is captured into the owner's `rdata`, and the owner's `rvalid` pulses in the following cycle. The state returns to IDLE in that same following cycle.
- **Streak counter (3 bits):**
  - Data grant with `if_req == 1`: increment, saturating at `MAX_STREAK`.
  - Data grant with `if_req == 0`: clear.
  - Fetch grant: clear.
- `gnt` is never asserted outside IDLE; both `gnt` signals are never high together.
- Strobes and `rvalid` are zero in all other cycles. `mem_adrs`/`mem_wdata` hold their last value, and `*_rdata` holds until the next capture.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - State IDLE; streak 0.
  - `mem_re`, `mem_we`, `if_rvalid`, `d_rvalid` = 0.
  - `mem_adrs`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - `busy` = 0; `gnt` = 0 while `resetn` is low.
- Read accepted in cycle T:
  - `mem_re` at T+1.
  - `mem_rdata` sampled at T+1+`RD_LAT`.
  - `rvalid` at T+2+`RD_LAT`, which is also the next IDLE, so a new grant is possible in that same cycle.
- Write accepted in cycle T: `mem_we` at T+1; next grant is possible at T+2.
- A `rvalid` pulse and a new grant may coincide.
- Reset asserted mid-access: immediate return to reset values. In-flight read data is discarded and no `rvalid` is produced. The requester re-requests after reset.
- A request dropped before `gnt` is a protocol violation; behaviour is undefined.

## Structure
- Shared `cpu_pkg`: `ADDR_W`/`DATA_W` defaults, opcode constants (LOAD, STORE, BRANCH, ADD, SUBTRACT, AND, OR, NOOP), and the FSM state enum.
- One natural sub-module: `arb_streak_cnt` (saturating counter with clear, which outputs `streak == MAX_STREAK`). The FSM and datapath registers stay in the top module.

## Test plan
- Fetch read, `RD_LAT`=2: `if_req` with `if_adrs`=0x005 at cycle 0; memory returns 0xDEADBEEF at cycle 3 → `if_gnt` at 0, `mem_re`/`mem_adrs`=0x005 at 1, `if_rvalid` with `if_rdata`=0xDEADBEEF at 4, `busy` at 1–3.
- Store: `d_req`, `d_we`, `d_adrs`=0x7FF, `d_wdata`=0x12345678 at 0 → `d_gnt` at 0, `mem_we` with matching address/data at 1, no `d_rvalid`, next grant possible at 2.
- Contention, `MAX_STREAK`=3: `if_req` and `d_req` held high, with each requester re-presenting a new request after its grant → grant order D,D,D,F,D,D,D,F.
- Back-to-back loads, `RD_LAT`=1: second `d_req` pending → second `d_gnt` in the same cycle as the first `d_rvalid` (3 cycles after the first grant).
- Reset in WAIT: `resetn` low for 1 cycle after `mem_re` → all outputs zero, no `rvalid`, streak 0. A subsequent fetch is served with nominal latency.
- Streak clear: 2 data grants with fetch waiting, then `d_req` low → fetch granted. Then 3 more data grants with fetch pending → fetch wins on the 4th.
